// File: rtl/risco5_fetch_pkg.sv
// Shared fetch-path types: the entry stored per fetched instruction and the canonical NOP.
package risco5_fetch_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

endpackage

// File: rtl/fetch_buffer_sync_fifo.sv
// sync_fifo: single-clock FIFO with flush and occupancy count; head is read asynchronously
// so a pushed entry is visible at the output the cycle after it is written.
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_array [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             do_push;
    logic             do_pop;

    assign do_push  = push && !flush && (count_reg != FULL_COUNT);
    assign do_pop   = pop && !flush && (count_reg != '0);
    assign pop_data = mem_array[rd_ptr_reg];
    assign count    = count_reg;

    // Storage carries no reset; validity is tracked purely by the pointers and count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_array[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/fetch_buffer.sv
// Instruction fetch buffer: sequential prefetch into a small FIFO with redirect flush.
// Define FETCH_BUFFER_BYPASS_EN to forward a response arriving into an empty FIFO straight to the core.
module fetch_buffer
    import risco5_fetch_pkg::*;
#(
    parameter int          DEPTH        = 4,
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] mem_address,
    output logic        mem_read,
    input  logic [31:0] mem_read_data,
    output logic        instruction_valid,
    output logic [31:0] instruction_data,
    output logic [31:0] instruction_pc,
    input  logic        instruction_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_address
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [31:0]  fetch_pc_reg;
    logic [31:0]  pending_pc_reg;
    logic         inflight_reg;
    logic [CW-1:0] fifo_count;
    logic         fifo_empty;
    logic         fifo_push;
    logic         fifo_pop;
    logic         resp_valid;
    logic         issue;
    fetch_entry_t resp_entry;
    fetch_entry_t head_entry;
    fetch_entry_t out_entry;

    // A response landing in a redirect cycle belongs to the old stream and is discarded.
    assign resp_valid = inflight_reg && !redirect;
    assign resp_entry = '{pc: pending_pc_reg, instr: mem_read_data};
    assign fifo_empty = (fifo_count == '0);

    // inflight is at most 1, so count + inflight never exceeds DEPTH.
    assign issue       = !reset && (redirect || ((fifo_count + CW'(inflight_reg)) < FULL_COUNT));
    assign mem_read    = issue;
    assign mem_address = (redirect && !reset) ? redirect_address : fetch_pc_reg;

    always_comb begin
        out_entry         = head_entry;
        instruction_valid = 1'b0;
        fifo_push         = 1'b0;
        fifo_pop          = 1'b0;
`ifdef FETCH_BUFFER_BYPASS_EN
        if (resp_valid && fifo_empty) begin
            out_entry = resp_entry;
        end
        instruction_valid = !reset && !redirect && (!fifo_empty || resp_valid);
        fifo_pop          = !reset && !redirect && !fifo_empty && instruction_ready;
        fifo_push         = resp_valid && !(fifo_empty && instruction_ready);
`else
        instruction_valid = !reset && !redirect && !fifo_empty;
        fifo_pop          = instruction_valid && instruction_ready;
        fifo_push         = resp_valid;
`endif
    end

    assign instruction_data = out_entry.instr;
    assign instruction_pc   = out_entry.pc;

    // Memory answers exactly one cycle after a request, so inflight simply mirrors the last issue.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_reg   <= RESET_VECTOR;
            pending_pc_reg <= RESET_VECTOR;
            inflight_reg   <= 1'b0;
        end else begin
            inflight_reg <= issue;
            if (issue) begin
                pending_pc_reg <= mem_address;
                fetch_pc_reg   <= mem_address + 32'd4;
            end
        end
    end

    sync_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect),
        .push      (fifo_push),
        .push_data (resp_entry),
        .pop       (fifo_pop),
        .pop_data  (head_entry),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer: memory word at byte address A holds 0x1000 + A/4.
module tb_fetch_buffer;

`ifdef FETCH_BUFFER_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic        clk;
    logic        reset;
    logic [31:0] mem_address;
    logic        mem_read;
    logic [31:0] mem_read_data;
    logic        instruction_valid;
    logic [31:0] instruction_data;
    logic [31:0] instruction_pc;
    logic        instruction_ready;
    logic        redirect;
    logic [31:0] redirect_address;

    int pass_count  = 0;
    int total_count = 0;

    fetch_buffer dut (
        .clk               (clk),
        .reset             (reset),
        .mem_address       (mem_address),
        .mem_read          (mem_read),
        .mem_read_data     (mem_read_data),
        .instruction_valid (instruction_valid),
        .instruction_data  (instruction_data),
        .instruction_pc    (instruction_pc),
        .instruction_ready (instruction_ready),
        .redirect          (redirect),
        .redirect_address  (redirect_address)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (mem_read) mem_read_data <= 32'h1000 + (mem_address >> 2);
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_count++;
        assert (got === exp) pass_count++;
        else $error("FAIL %s: observed %h expected %h", tag, got, exp);
        $display("check %-14s observed %h expected %h", tag, got, exp);
    endtask

    task automatic chk_head(input string tag, input logic [31:0] pc, input logic [31:0] data);
        chk({tag, "_valid"}, {31'd0, instruction_valid}, 32'd1);
        chk({tag, "_pc"}, instruction_pc, pc);
        chk({tag, "_data"}, instruction_data, data);
    endtask

    initial begin
        reset = 1'b1; instruction_ready = 1'b0; redirect = 1'b0; redirect_address = 32'h0;
        mem_read_data = 32'h0;

        // Reset state
        repeat (2) cycle();
        sample();
        chk("rst_valid", {31'd0, instruction_valid}, 32'd0);
        chk("rst_memrd", {31'd0, mem_read}, 32'd0);
        chk("rst_addr", mem_address, 32'h0);

        // Streaming with core always ready
        cycle(); reset = 1'b0; instruction_ready = 1'b1;
        sample();
        chk("first_rd", {31'd0, mem_read}, 32'd1);
        chk("first_addr", mem_address, 32'h0);
        repeat (LAT) cycle();
        for (int i = 0; i < 6; i++) begin
            sample();
            chk_head("stream", 32'(4 * i), 32'h1000 + 32'(i));
            cycle();
        end

        // Back-pressure until FIFO is full, then drain without gaps
        reset = 1'b1; instruction_ready = 1'b0;
        cycle(); reset = 1'b0;
        repeat (9) cycle();
        sample();
        chk("full_memrd", {31'd0, mem_read}, 32'd0);
        chk_head("full_head", 32'h0, 32'h1000);
        cycle(); instruction_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            sample();
            chk_head("drain", 32'(4 * i), 32'h1000 + 32'(i));
            cycle();
        end

        // Redirect with three entries queued
        reset = 1'b1; instruction_ready = 1'b0;
        cycle(); reset = 1'b0;
        repeat (4) cycle();
        redirect = 1'b1; redirect_address = 32'h40; instruction_ready = 1'b1;
        sample();
        chk("redir_valid", {31'd0, instruction_valid}, 32'd0);
        chk("redir_memrd", {31'd0, mem_read}, 32'd1);
        chk("redir_addr", mem_address, 32'h40);
        cycle(); redirect = 1'b0;
        repeat (LAT - 1) cycle();
        sample();
        chk_head("redir_a", 32'h40, 32'h1010);
        cycle();
        sample();
        chk_head("redir_b", 32'h44, 32'h1011);

        // Redirect wins over ready, then back-to-back redirect
        redirect = 1'b1; redirect_address = 32'h60;
        sample();
        chk("rr1_valid", {31'd0, instruction_valid}, 32'd0);
        chk("rr1_addr", mem_address, 32'h60);
        cycle(); redirect_address = 32'h80;
        sample();
        chk("rr2_valid", {31'd0, instruction_valid}, 32'd0);
        chk("rr2_addr", mem_address, 32'h80);
        cycle(); redirect = 1'b0;
        repeat (LAT - 1) cycle();
        sample();
        chk_head("rr_a", 32'h80, 32'h1020);
        cycle();
        sample();
        chk_head("rr_b", 32'h84, 32'h1021);

        // Reset mid-stream
        cycle(); reset = 1'b1;
        cycle(); reset = 1'b0;
        repeat (LAT + 8) cycle();
        sample();
        chk_head("mid_0x20", 32'h20, 32'h1008);
        cycle(); reset = 1'b1;
        sample();
        chk("mrst_valid", {31'd0, instruction_valid}, 32'd0);
        chk("mrst_memrd", {31'd0, mem_read}, 32'd0);
        chk("mrst_addr", mem_address, 32'h0);
        cycle(); reset = 1'b0;
        sample();
        chk("mrst_rd", {31'd0, mem_read}, 32'd1);
        chk("mrst_addr2", mem_address, 32'h0);
        repeat (LAT) cycle();
        sample();
        chk_head("mrst_head", 32'h0, 32'h1000);

        // Address wrap at top of memory
        redirect = 1'b1; redirect_address = 32'hFFFF_FFFC;
        cycle(); redirect = 1'b0;
        repeat (LAT - 1) cycle();
        sample();
        chk_head("wrap_a", 32'hFFFF_FFFC, 32'h4000_0FFF);
        cycle();
        sample();
        chk_head("wrap_b", 32'h0, 32'h1000);

        $display("%0d/%0d checks passed", pass_count, total_count);
        $finish;
    end

endmodule
